// File: rtl/cnt_bank_pkg.sv
// Shared types and default sizes for the multi-channel counter bank.
package cnt_bank_pkg;

    typedef enum logic {CNT_UP, CNT_DN} cnt_dir_e;
    typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_e;

    localparam int unsigned CNT_NCH_DEF = 4;
    localparam int unsigned CNT_WL_DEF  = 16;

endpackage

// File: rtl/cnt_bank_if.sv
// Control/status bundle of the counter bank; CNT_BANK_OVF_STICKY_EN adds the
// sticky overflow flags and their clears.
interface cnt_bank_if
    import cnt_bank_pkg::*;
#(
    parameter int unsigned NCH = CNT_NCH_DEF,
    parameter int unsigned WL  = CNT_WL_DEF
);

    logic [NCH-1:0]         en;
    logic [NCH-1:0]         clr;
    logic [NCH-1:0]         ld;
    logic [NCH-1:0][WL-1:0] ld_val;
    logic [NCH-1:0]         dn;
    logic [NCH-1:0]         sat;
    logic [NCH-1:0][WL-1:0] lim;
    logic [NCH-1:0][WL-1:0] cnt;
    logic [NCH-1:0]         evt;
    logic [NCH-1:0]         at_max;
    logic [NCH-1:0]         at_zero;
`ifdef CNT_BANK_OVF_STICKY_EN
    logic [NCH-1:0]         ovf_clr;
    logic [NCH-1:0]         ovf;

    modport master (
        output en, clr, ld, ld_val, dn, sat, lim, ovf_clr,
        input  cnt, evt, at_max, at_zero, ovf
    );
    modport slave (
        input  en, clr, ld, ld_val, dn, sat, lim, ovf_clr,
        output cnt, evt, at_max, at_zero, ovf
    );
`else
    modport master (
        output en, clr, ld, ld_val, dn, sat, lim,
        input  cnt, evt, at_max, at_zero
    );
    modport slave (
        input  en, clr, ld, ld_val, dn, sat, lim,
        output cnt, evt, at_max, at_zero
    );
`endif

endinterface

// File: rtl/cnt_chan.sv
// One counter channel: clear/load/count next-state logic with registered cnt/evt
// (and sticky ovf when CNT_BANK_OVF_STICKY_EN is defined).
module cnt_chan
    import cnt_bank_pkg::*;
#(
    parameter int unsigned WL = CNT_WL_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic          clr_i,
    input  logic          ld_i,
    input  logic [WL-1:0] ld_val_i,
    input  logic          dn_i,
    input  logic          sat_i,
    input  logic [WL-1:0] lim_i,
`ifdef CNT_BANK_OVF_STICKY_EN
    input  logic          ovf_clr_i,
    output logic          ovf_o,
`endif
    output logic [WL-1:0] cnt_o,
    output logic          evt_o,
    output logic          at_max_o,
    output logic          at_zero_o
);

    localparam logic [WL-1:0] ZERO = {WL{1'b0}};
    localparam logic [WL-1:0] ONE  = {{(WL-1){1'b0}}, 1'b1};

    logic [WL-1:0] cnt_q, cnt_d;
    logic          evt_q, evt_d;
    cnt_dir_e      dir_s;
    cnt_mode_e     mode_s;

    assign dir_s  = cnt_dir_e'(dn_i);
    assign mode_s = cnt_mode_e'(sat_i);

    // Next count and event: clr beats ld beats en; a count above lim acts as lim.
    always_comb begin
        cnt_d = cnt_q;
        evt_d = 1'b0;
        if (clr_i) begin
            cnt_d = ZERO;
        end else if (ld_i) begin
            cnt_d = (ld_val_i > lim_i) ? lim_i : ld_val_i;
        end else if (en_i) begin
            case (dir_s)
                CNT_UP: begin
                    if (cnt_q < lim_i) begin
                        cnt_d = cnt_q + ONE;
                    end else begin
                        evt_d = 1'b1;
                        cnt_d = (mode_s == CNT_SAT) ? lim_i : ZERO;
                    end
                end
                CNT_DN: begin
                    if (cnt_q != ZERO) begin
                        cnt_d = cnt_q - ONE;
                    end else begin
                        evt_d = 1'b1;
                        cnt_d = (mode_s == CNT_SAT) ? ZERO : lim_i;
                    end
                end
                default: begin
                    cnt_d = cnt_q;
                    evt_d = 1'b0;
                end
            endcase
        end else begin
            cnt_d = cnt_q;
            evt_d = 1'b0;
        end
    end

    // Counter and event registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= ZERO;
            evt_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            evt_q <= evt_d;
        end
    end

`ifdef CNT_BANK_OVF_STICKY_EN
    logic ovf_q, ovf_d;

    // Sticky overflow: a new event wins over a same-cycle clear.
    always_comb begin
        ovf_d = ovf_q;
        if (evt_d) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;
`endif

    assign cnt_o     = cnt_q;
    assign evt_o     = evt_q;
    assign at_max_o  = (cnt_q == lim_i);
    assign at_zero_o = (cnt_q == ZERO);

endmodule

// File: rtl/cnt_bank.sv
// NCH independent up/down counters with runtime limit, wrap/saturate and event
// pulse. Optional sticky overflow flags via CNT_BANK_OVF_STICKY_EN.
module cnt_bank
    import cnt_bank_pkg::*;
#(
    parameter int unsigned NCH = CNT_NCH_DEF,
    parameter int unsigned WL  = CNT_WL_DEF
) (
    input logic      clk,
    input logic      rst,
    cnt_bank_if.slave bus
);

    logic [NCH-1:0][WL-1:0] cnt_s;
    logic [NCH-1:0]         evt_s;
    logic [NCH-1:0]         at_max_s;
    logic [NCH-1:0]         at_zero_s;
`ifdef CNT_BANK_OVF_STICKY_EN
    logic [NCH-1:0]         ovf_s;
`endif

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        cnt_chan #(
            .WL (WL)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .en_i      (bus.en[g]),
            .clr_i     (bus.clr[g]),
            .ld_i      (bus.ld[g]),
            .ld_val_i  (bus.ld_val[g]),
            .dn_i      (bus.dn[g]),
            .sat_i     (bus.sat[g]),
            .lim_i     (bus.lim[g]),
`ifdef CNT_BANK_OVF_STICKY_EN
            .ovf_clr_i (bus.ovf_clr[g]),
            .ovf_o     (ovf_s[g]),
`endif
            .cnt_o     (cnt_s[g]),
            .evt_o     (evt_s[g]),
            .at_max_o  (at_max_s[g]),
            .at_zero_o (at_zero_s[g])
        );
    end

    assign bus.cnt     = cnt_s;
    assign bus.evt     = evt_s;
    assign bus.at_max  = at_max_s;
    assign bus.at_zero = at_zero_s;
`ifdef CNT_BANK_OVF_STICKY_EN
    assign bus.ovf     = ovf_s;
`endif

endmodule

// File: tb/tb_cnt_bank.sv
// Scoreboard bench for cnt_bank: directed scenarios then random traffic, each
// cycle's expected outputs come from an integer reference model.
module tb_cnt_bank;

    localparam int NCH = 4;
    localparam int WL  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cnt_bank_if #(.NCH(NCH), .WL(WL)) bus ();

    cnt_bank #(.NCH(NCH), .WL(WL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [NCH-1:0][WL-1:0] cnt;
        logic [NCH-1:0]         evt;
        logic [NCH-1:0]         amax;
        logic [NCH-1:0]         azero;
        logic [NCH-1:0]         ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_cnt[NCH];
    bit   m_ovf[NCH];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, got, want, $time);
        end
    endtask

    // Reference model: apply the rules to this cycle's inputs, queue the result, clock once.
    task automatic commit();
        exp_t e;
        int   lim_v, ldv;
        e = '0;
        for (int i = 0; i < NCH; i++) begin
            lim_v = int'(bus.lim[i]);
            ldv   = int'(bus.ld_val[i]);
            if (rst) begin
                m_cnt[i] = 0;
                m_ovf[i] = 1'b0;
            end else begin
                if (bus.clr[i]) m_cnt[i] = 0;
                else if (bus.ld[i]) m_cnt[i] = (ldv < lim_v) ? ldv : lim_v;
                else if (bus.en[i]) begin
                    if (!bus.dn[i]) begin
                        if (m_cnt[i] >= lim_v) begin
                            e.evt[i] = 1'b1;
                            m_cnt[i] = bus.sat[i] ? lim_v : 0;
                        end else m_cnt[i] = m_cnt[i] + 1;
                    end else begin
                        if (m_cnt[i] == 0) begin
                            e.evt[i] = 1'b1;
                            m_cnt[i] = bus.sat[i] ? 0 : lim_v;
                        end else m_cnt[i] = m_cnt[i] - 1;
                    end
                end
`ifdef CNT_BANK_OVF_STICKY_EN
                if (e.evt[i]) m_ovf[i] = 1'b1;
                else if (bus.ovf_clr[i]) m_ovf[i] = 1'b0;
`endif
            end
            e.cnt[i]   = WL'(m_cnt[i]);
            e.amax[i]  = (m_cnt[i] == lim_v);
            e.azero[i] = (m_cnt[i] == 0);
            e.ovf[i]   = m_ovf[i];
        end
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_ch(input int ch, input bit en, input bit clr, input bit ld,
                          input int ldv, input bit dn, input bit sat, input int lim);
        bus.en[ch]     = en;
        bus.clr[ch]    = clr;
        bus.ld[ch]     = ld;
        bus.ld_val[ch] = WL'(ldv);
        bus.dn[ch]     = dn;
        bus.sat[ch]    = sat;
        bus.lim[ch]    = WL'(lim);
    endtask

    // Monitor: outputs are valid every cycle, compare just after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("cnt",     64'(bus.cnt),     64'(e.cnt));
                chk("evt",     64'(bus.evt),     64'(e.evt));
                chk("at_max",  64'(bus.at_max),  64'(e.amax));
                chk("at_zero", 64'(bus.at_zero), 64'(e.azero));
`ifdef CNT_BANK_OVF_STICKY_EN
                chk("ovf",     64'(bus.ovf),     64'(e.ovf));
`endif
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            set_ch(i, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 15);
            m_cnt[i] = 0;
            m_ovf[i] = 1'b0;
        end
`ifdef CNT_BANK_OVF_STICKY_EN
        bus.ovf_clr = '0;
`endif
        @(negedge clk);
        // Reset with everything enabled, then idle.
        commit();
        commit();
        rst = 1'b0;
        bus.en = '0;
        repeat (5) commit();
        // Up-wrap at lim 5 on ch0.
        set_ch(0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 5);
        repeat (7) commit();
        bus.en[0] = 1'b0;
        // Load 2 then saturate downward on ch1.
        set_ch(1, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b1, 9);
        commit();
        set_ch(1, 1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b1, 9);
        repeat (4) commit();
        bus.en[1] = 1'b0;
        // Priority then clamped load on ch2.
        set_ch(2, 1'b1, 1'b1, 1'b1, 5, 1'b0, 1'b0, 15);
        commit();
        set_ch(2, 1'b0, 1'b0, 1'b1, 12, 1'b0, 1'b0, 7);
        commit();
        bus.ld[2] = 1'b0;
        // Runtime limit drop on ch3, wrap then saturate.
        set_ch(3, 1'b0, 1'b0, 1'b1, 10, 1'b0, 1'b0, 15);
        commit();
        set_ch(3, 1'b1, 1'b0, 1'b0, 10, 1'b0, 1'b0, 4);
        commit();
        set_ch(3, 1'b0, 1'b0, 1'b1, 10, 1'b0, 1'b1, 15);
        commit();
        set_ch(3, 1'b1, 1'b0, 1'b0, 10, 1'b0, 1'b1, 4);
        commit();
        commit();
        bus.en[3] = 1'b0;
        // Degenerate lim 0, both directions, plus full-range free-running wrap on ch1.
        set_ch(0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
        set_ch(1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 15);
        repeat (2) commit();
        bus.dn[0] = 1'b1;
        repeat (2) commit();
        bus.dn[0] = 1'b0;
        repeat (16) commit();
        // Independence: ch0 wraps quickly while ch1 keeps counting.
        set_ch(0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1);
        set_ch(1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 15);
        commit();
        bus.clr = '0;
        repeat (4) commit();
        bus.en[0] = 1'b0;
        repeat (3) commit();
`ifdef CNT_BANK_OVF_STICKY_EN
        bus.ovf_clr[0] = 1'b1;
        commit();
        bus.ovf_clr[0] = 1'b0;
        commit();
`endif
        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < NCH; i++) begin
                bus.en[i]     = ($urandom_range(0, 3) != 0);
                bus.clr[i]    = ($urandom_range(0, 31) == 0);
                bus.ld[i]     = ($urandom_range(0, 15) == 0);
                bus.ld_val[i] = WL'($urandom);
                if ($urandom_range(0, 7) == 0) bus.dn[i] = ~bus.dn[i];
                if ($urandom_range(0, 15) == 0) bus.sat[i] = ~bus.sat[i];
                if ($urandom_range(0, 15) == 0) begin
                    case ($urandom_range(0, 3))
                        0: bus.lim[i] = '0;
                        1: bus.lim[i] = '1;
                        default: bus.lim[i] = WL'($urandom);
                    endcase
                end
`ifdef CNT_BANK_OVF_STICKY_EN
                bus.ovf_clr[i] = ($urandom_range(0, 7) == 0);
`endif
            end
            commit();
        end
        rst = 1'b0;
        n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cnt_bank.md
Name: cnt_bank

Overview:
- Parametrised multi-channel successor to the single up-counter used for memory-entry bookkeeping.
- Provides NCH independent counters, each WL bits wide. Every channel supports:
  - up/down counting
  - synchronous clear and parallel load
  - a runtime limit, with wrap or saturate mode per channel
  - a registered wrap/saturate event pulse
- Sits beside the replay/experience memory controllers to track read pointers, write pointers and fill levels for several buffers at once.

Parameters:
- NCH, 4, number of independent channels (≥1).
- WL, 16, counter width per channel (≥2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  [NCH-1:0]  per-channel count enable.
- clr  input  [NCH-1:0]  per-channel synchronous clear to 0.
- ld  input  [NCH-1:0]  per-channel parallel load.
- ld_val  input  [NCH-1:0][WL-1:0]  load values.
- dn  input  [NCH-1:0]  direction: 0 = up, 1 = down.
- sat  input  [NCH-1:0]  mode: 0 = wrap, 1 = saturate.
- lim  input  [NCH-1:0][WL-1:0]  per-channel terminal value (inclusive max).
- cnt  output  [NCH-1:0][WL-1:0]  registered counter values.
- evt  output  [NCH-1:0]  registered 1-cycle pulse on wrap/saturate event.
- at_max  output  [NCH-1:0]  combinational flag, cnt == lim.
- at_zero  output  [NCH-1:0]  combinational flag, cnt == 0.

Behaviour:
- Reset:
  - Single clock domain. Reset is synchronous and active-high: rst sampled high at a rising clk edge forces every cnt to 0 and every evt to 0. All other inputs are ignored that cycle.
  - Reset asserted mid-count aborts in the same edge; there is no partial update.
- Per-channel priority: rst > clr > ld > en. Channels are fully independent; a simultaneous clr and ld on one channel resolves to clr.
- clr: cnt <= 0; evt <= 0.
- ld: cnt <= min(ld_val, lim); evt <= 0. A load above lim is clamped to lim, never stored raw.
- en, up count (dn = 0):
  - cnt < lim: cnt <= cnt + 1, evt <= 0.
  - cnt == lim, wrap mode: cnt <= 0, evt <= 1.
  - cnt == lim, sat mode: cnt holds, evt <= 1.
  - cnt > lim (lim was lowered at runtime): treated as cnt == lim, i.e. wrap to 0 or clamp to lim, evt <= 1.
- en, down count (dn = 1):
  - cnt > 0: cnt <= cnt - 1, evt <= 0.
  - cnt == 0, wrap mode: cnt <= lim, evt <= 1.
  - cnt == 0, sat mode: cnt holds, evt <= 1.
- en low (and no clr/ld): cnt holds; evt <= 0.
- evt is a pulse, not a level. A saturated channel with en held high re-asserts evt every enabled cycle.
- Latency: one cycle from enable edge to cnt update; evt is valid in the same cycle as the updated cnt.
- Arithmetic: unsigned, modulo 2^WL. With lim = 2^WL - 1 the block reproduces plain free-running wrap behaviour.
- Degenerate lim = 0: up and down both produce an event every enabled cycle; cnt stays 0.
- at_max and at_zero are derived combinationally from registered cnt and the current lim; no state.

Optional Feature:
- Macro: CNT_BANK_OVF_STICKY_EN.
- When defined:
  - Adds input ovf_clr [NCH-1:0] and output ovf [NCH-1:0].
  - ovf[i] sets on any cycle where evt[i] is being set, and holds until ovf_clr[i] or rst.
  - Simultaneous set and ovf_clr resolves to set.
  - rst clears ovf to 0.
- When undefined: those ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package cnt_bank_pkg:
  - typedef enum logic {CNT_UP, CNT_DN} cnt_dir_e.
  - typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_e.
  - Default-width localparams.
- Sub-module cnt_chan:
  - Single-channel next-state logic plus registers (cnt, evt, optional ovf), using the team's register primitive.
  - cnt_bank is a generate loop of NCH cnt_chan instances.

Test Plan:
- Reset/hold: rst for 2 cycles with en = all 1 -> all cnt = 0, evt = 0; after rst drops, en = 0 for 5 cycles -> cnt stays 0.
- Up-wrap: WL = 4, lim = 5, sat = 0, en = 1 for 7 cycles -> cnt sequence 1, 2, 3, 4, 5, 0, 1; evt high only in the cycle cnt reads 0.
- Down-saturate: lim = 9, ld_val = 2, ld then dn = 1, sat = 1, en for 4 cycles -> cnt 2, 1, 0, 0, 0; evt high in the last two cycles.
- Priority/clamp: clr = ld = en = 1 together -> cnt = 0; then ld_val = 12 with lim = 7 -> cnt = 7, evt = 0.
- Runtime lim drop: cnt = 10, lim changed to 4, en up with sat = 0 -> cnt = 0, evt = 1; with sat = 1 -> cnt = 4, evt = 1.
- Channel independence plus sticky flag (CNT_BANK_OVF_STICKY_EN defined): wrap ch0 only while ch1 counts -> ch1 unaffected; ovf[0] = 1 persists until ovf_clr[0] = 1, then ovf[0] = 0.
